// File: rtl/sdes_arbiter_ctrl_pkg.sv
// Shared definitions for the S-DES round-robin job controller.
package sdes_arbiter_ctrl_pkg;

  // Job sequencing states, one job walks IDLE through RESP exactly once
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    KEYGEN  = 3'd2,
    ENCRYPT = 3'd3,
    CAPTURE = 3'd4,
    RESP    = 3'd5
  } state_t;

  // Field positions inside a 16-bit request operand {key, plaintext}
  localparam int KEY_MSB = 15;
  localparam int KEY_LSB = 8;
  localparam int PT_MSB  = 7;
  localparam int PT_LSB  = 0;

  // Cycles from request handshake to rsp_valid
  localparam int RSP_LAT = 5;

endpackage

// File: rtl/sdes_arbiter_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above the
// pointer, wrapping modulo NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [NUM_REQ-1:0] o_grant_onehot,
  output logic [ID_W-1:0]    o_grant_idx,
  output logic               o_any_req
);

  logic [ID_W-1:0] w_idx [NUM_REQ];

  // Requester index visited at each search offset from the pointer
  always_comb begin
    for (int off = 0; off < NUM_REQ; off++) begin
      w_idx[off] = ID_W'((int'(i_ptr) + off) % NUM_REQ);
    end
  end

  // Scan from the farthest offset down so the nearest requester wins last
  always_comb begin
    o_grant_onehot = '0;
    o_grant_idx    = '0;
    o_any_req      = |i_req;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      if (i_req[w_idx[off]]) begin
        o_grant_onehot             = '0;
        o_grant_onehot[w_idx[off]] = 1'b1;
        o_grant_idx                = w_idx[off];
      end
    end
  end

endmodule

// File: rtl/sdes_arbiter_ctrl.sv
// Round-robin job controller sharing one S-DES datapath among NUM_REQ
// requesters: accept, sequence load/keygen/encrypt, return tagged result.
module sdes_arbiter_ctrl
  import sdes_arbiter_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [16*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [15:0]           eng_data,
  output logic                  eng_read_en,
  output logic                  eng_key_en,
  output logic                  eng_encrypt_en,
  input  logic [7:0]            eng_result,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [7:0]            rsp_data,
  output logic                  busy
);

  state_t              r_state;
  state_t              w_next;
  logic [ID_W-1:0]     r_ptr;
  logic [ID_W-1:0]     r_gid;
  logic [15:0]         r_op;
  logic [7:0]          r_rsp_data;
  logic [ID_W-1:0]     r_rsp_id;

  logic [NUM_REQ-1:0]  w_grant;
  logic [ID_W-1:0]     w_gidx;
  logic                w_any;
  logic [15:0]         w_sel;
  logic                w_accept;
  logic                w_rsp_done;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .i_req          (req_valid),
    .i_ptr          (r_ptr),
    .o_grant_onehot (w_grant),
    .o_grant_idx    (w_gidx),
    .o_any_req      (w_any)
  );

  assign w_sel      = req_data[16*w_gidx +: 16];
  assign w_accept   = (r_state == IDLE) && w_any && !reset;
  assign w_rsp_done = rsp_valid && rsp_ready;
  assign rsp_data   = r_rsp_data;
  assign rsp_id     = r_rsp_id;

  // Next-state and per-state outputs; reset forces every control output low
  // in the same cycle so an abandoned job never reaches the datapath
  always_comb begin
    w_next         = r_state;
    req_ready      = '0;
    eng_data       = '0;
    eng_read_en    = 1'b0;
    eng_key_en     = 1'b0;
    eng_encrypt_en = 1'b0;
    rsp_valid      = 1'b0;
    busy           = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          req_ready = w_grant;
          w_next    = LOAD;
        end
      end
      LOAD: begin
        eng_read_en = 1'b1;
        w_next      = KEYGEN;
      end
      KEYGEN: begin
        eng_key_en = 1'b1;
        w_next     = ENCRYPT;
      end
      ENCRYPT: begin
        eng_encrypt_en = 1'b1;
        w_next         = CAPTURE;
      end
      CAPTURE: begin
        w_next = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
    if (r_state != IDLE) begin
      eng_data = r_op;
      busy     = 1'b1;
    end
    if (reset) begin
      req_ready      = '0;
      eng_data       = '0;
      eng_read_en    = 1'b0;
      eng_key_en     = 1'b0;
      eng_encrypt_en = 1'b0;
      rsp_valid      = 1'b0;
      busy           = 1'b0;
    end
  end

  // State, RR pointer and response registers; the pointer moves only when a
  // response completes, to the requester after the one just served
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_rsp_data <= '0;
      r_rsp_id   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == CAPTURE) begin
        r_rsp_data <= eng_result;
        r_rsp_id   <= r_gid;
      end
      if (w_rsp_done) begin
        r_ptr <= (r_gid == ID_W'(NUM_REQ - 1)) ? '0 : r_gid + 1'b1;
      end
    end
  end

  // Operand and winner captured at the handshake so later req_data changes
  // cannot disturb the job in flight
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_op  <= {w_sel[KEY_MSB:KEY_LSB], w_sel[PT_MSB:PT_LSB]};
      r_gid <= w_gidx;
    end
  end

endmodule

// File: tb/tb_sdes_arbiter_ctrl.sv
// Self-checking bench for sdes_arbiter_ctrl with an S-DES datapath model
// and a transaction-level reference of scheduling and latency.
module tb_sdes_arbiter_ctrl;

  localparam int N    = 4;
  localparam int ID_W = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req_valid;
  logic [16*N-1:0]   req_data;
  logic [N-1:0]      req_ready;
  logic [15:0]       eng_data;
  logic              eng_read_en;
  logic              eng_key_en;
  logic              eng_encrypt_en;
  logic [7:0]        eng_result;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [ID_W-1:0]   rsp_id;
  logic [7:0]        rsp_data;
  logic              busy;

  int n_chk  = 0;
  int n_fail = 0;

  sdes_arbiter_ctrl #(.NUM_REQ(N), .ID_W(ID_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .eng_data       (eng_data),
    .eng_read_en    (eng_read_en),
    .eng_key_en     (eng_key_en),
    .eng_encrypt_en (eng_encrypt_en),
    .eng_result     (eng_result),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_id         (rsp_id),
    .rsp_data       (rsp_data),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // ---------------- S-DES golden function ----------------
  localparam logic [1:0] S0 [16] = '{2'd1, 2'd0, 2'd3, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0,
                                     2'd0, 2'd2, 2'd1, 2'd3, 2'd3, 2'd1, 2'd3, 2'd2};
  localparam logic [1:0] S1 [16] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd0, 2'd1, 2'd3,
                                     2'd3, 2'd0, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0, 2'd3};

  // Generic permutation: table holds 1-based MSB-first source positions
  function automatic logic [9:0] perm(input logic [9:0] x, input int n_in,
                                      input logic [39:0] tbl, input int n_out);
    logic [9:0] r;
    int idx;
    r = '0;
    for (int k = 0; k < n_out; k++) begin
      idx = int'(tbl[4*(n_out-1-k) +: 4]);
      r[n_out-1-k] = x[n_in-idx];
    end
    return r;
  endfunction

  function automatic logic [7:0] fk(input logic [7:0] b, input logic [7:0] sk);
    logic [9:0] ep;
    logic [9:0] p4;
    logic [7:0] x;
    logic [1:0] s0v;
    logic [1:0] s1v;
    ep  = perm({6'b0, b[3:0]}, 4, 40'h41232341, 8);
    x   = ep[7:0] ^ sk;
    s0v = S0[{x[7], x[4], x[6], x[5]}];
    s1v = S1[{x[3], x[0], x[2], x[1]}];
    p4  = perm({6'b0, s0v, s1v}, 4, 40'h2431, 4);
    return {b[7:4] ^ p4[3:0], b[3:0]};
  endfunction

  function automatic logic [7:0] sdes(input logic [7:0] key8, input logic [7:0] pt);
    logic [9:0] p;
    logic [4:0] l;
    logic [4:0] r;
    logic [9:0] t;
    logic [7:0] k1;
    logic [7:0] k2;
    logic [7:0] a;
    p  = perm({2'b11, key8}, 10, 40'h35274A1986, 10);
    l  = {p[8:5], p[9]};
    r  = {p[3:0], p[4]};
    t  = perm({l, r}, 10, 40'h637485A9, 8);
    k1 = t[7:0];
    l  = {l[2:0], l[4:3]};
    r  = {r[2:0], r[4:3]};
    t  = perm({l, r}, 10, 40'h637485A9, 8);
    k2 = t[7:0];
    t  = perm({2'b0, pt}, 8, 40'h26314857, 8);
    a  = fk(t[7:0], k1);
    a  = fk({a[3:0], a[7:4]}, k2);
    t  = perm({2'b0, a}, 8, 40'h41357286, 8);
    return t[7:0];
  endfunction

  // ---------------- datapath model ----------------
  // Result is valid only in the cycle after the encrypt enable; noise otherwise
  logic [15:0] dp_op;
  logic [7:0]  dp_key;
  logic [7:0]  dp_res;
  logic        dp_fresh = 1'b0;
  logic [7:0]  dp_noise = 8'h00;

  always @(posedge clk) begin
    dp_noise <= 8'($urandom);
    if (eng_read_en) dp_op <= eng_data;
    if (eng_key_en)  dp_key <= dp_op[15:8];
    dp_fresh <= eng_encrypt_en;
    if (eng_encrypt_en) dp_res <= sdes(dp_key, dp_op[7:0]);
  end

  assign eng_result = dp_fresh ? dp_res : dp_noise;

  // ---------------- checking ----------------
  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model state ----------------
  int          cyc       = 0;
  bit          m_in_job  = 0;
  int          m_t       = 0;
  int          m_id      = 0;
  logic [15:0] m_op      = '0;
  int          m_ptr     = 0;
  bit          m_after_rst = 0;
  bit          gap_on    = 0;
  int          last_grant = -1;

  // One clock: drive inputs, then compare outputs against the reference
  task automatic run_cycle(input logic rst_i, input logic [N-1:0] vld_i,
                           input logic [16*N-1:0] data_i, input logic rdy_i);
    logic [N-1:0] exp_ready;
    int g;
    int d;
    @(posedge clk);
    #1;
    reset     = rst_i;
    req_valid = vld_i;
    req_data  = data_i;
    rsp_ready = rdy_i;
    #1;
    cyc++;
    if (rst_i) begin
      chk_eq("rst_read_en", 32'(eng_read_en), 0);
      chk_eq("rst_key_en", 32'(eng_key_en), 0);
      chk_eq("rst_enc_en", 32'(eng_encrypt_en), 0);
      chk_eq("rst_req_ready", 32'(req_ready), 0);
      m_in_job    = 0;
      m_ptr       = 0;
      m_after_rst = 1;
      last_grant  = -1;
      return;
    end
    if (m_after_rst) begin
      chk_eq("post_rst_rsp_valid", 32'(rsp_valid), 0);
      chk_eq("post_rst_rsp_data", 32'(rsp_data), 0);
      chk_eq("post_rst_rsp_id", 32'(rsp_id), 0);
      chk_eq("post_rst_busy", 32'(busy), 0);
      chk_eq("post_rst_eng_data", 32'(eng_data), 0);
      m_after_rst = 0;
    end
    if (!m_in_job) begin
      exp_ready = '0;
      g = -1;
      for (int off = 0; off < N; off++) begin
        if (g < 0 && vld_i[(m_ptr + off) % N]) g = (m_ptr + off) % N;
      end
      chk_eq("idle_busy", 32'(busy), 0);
      chk_eq("idle_eng_data", 32'(eng_data), 0);
      chk_eq("idle_enables", 32'({eng_read_en, eng_key_en, eng_encrypt_en}), 0);
      chk_eq("idle_rsp_valid", 32'(rsp_valid), 0);
      if (g >= 0) begin
        exp_ready[g] = 1'b1;
        if (gap_on && last_grant >= 0) chk_eq("grant_gap", 32'(cyc - last_grant), 6);
        last_grant = cyc;
        m_in_job = 1;
        m_t      = cyc;
        m_id     = g;
        m_op     = data_i[16*g +: 16];
      end
      chk_eq("req_ready", 32'(req_ready), 32'(exp_ready));
    end else begin
      d = cyc - m_t;
      chk_eq("job_req_ready", 32'(req_ready), 0);
      chk_eq("job_busy", 32'(busy), 1);
      chk_eq("job_eng_data", 32'(eng_data), 32'(m_op));
      chk_eq("read_en", 32'(eng_read_en), 32'(d == 1));
      chk_eq("key_en", 32'(eng_key_en), 32'(d == 2));
      chk_eq("encrypt_en", 32'(eng_encrypt_en), 32'(d == 3));
      chk_eq("rsp_valid", 32'(rsp_valid), 32'(d >= 5));
      if (d >= 5) begin
        chk_eq("rsp_id", 32'(rsp_id), 32'(m_id));
        chk_eq("rsp_data", 32'(rsp_data), 32'(sdes(m_op[15:8], m_op[7:0])));
        if (rdy_i) begin
          m_in_job = 0;
          m_ptr    = (m_id + 1) % N;
        end
      end
    end
  endtask

  function automatic logic [16*N-1:0] rand_data();
    logic [16*N-1:0] r;
    for (int i = 0; i < N; i++) r[16*i +: 16] = 16'($urandom);
    return r;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [16*N-1:0] dat;
    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) run_cycle(1'b1, '0, '0, 1'b0);

    // Single request from requester 0
    dat = rand_data();
    dat[15:0] = 16'hA53C;
    run_cycle(1'b0, 4'b0001, dat, 1'b1);
    for (int i = 0; i < 7; i++) run_cycle(1'b0, 4'b0000, dat, 1'b1);

    // All requesters valid, full throughput
    gap_on = 1;
    last_grant = -1;
    for (int i = 0; i < 32; i++) run_cycle(1'b0, 4'b1111, rand_data(), 1'b1);
    gap_on = 0;
    for (int i = 0; i < 8; i++) run_cycle(1'b0, 4'b0000, dat, 1'b1);

    // Backpressure with requester 2 pending
    dat = rand_data();
    for (int i = 0; i < 16; i++) run_cycle(1'b0, 4'b0100, dat, 1'b0);
    for (int i = 0; i < 8; i++) run_cycle(1'b0, 4'b0100, dat, 1'b1);

    // Pointer wrap after serving requester 2
    for (int i = 0; i < 14; i++) run_cycle(1'b0, 4'b0011, rand_data(), 1'b1);
    for (int i = 0; i < 8; i++) run_cycle(1'b0, 4'b0000, dat, 1'b1);

    // Reset during ENCRYPT, then requester 1 with pointer back at 0
    dat = rand_data();
    run_cycle(1'b0, 4'b0100, dat, 1'b1);
    run_cycle(1'b0, 4'b0000, dat, 1'b1);
    run_cycle(1'b0, 4'b0000, dat, 1'b1);
    run_cycle(1'b1, 4'b0000, dat, 1'b1);
    run_cycle(1'b0, 4'b0000, dat, 1'b1);
    run_cycle(1'b0, 4'b0000, dat, 1'b1);
    for (int i = 0; i < 8; i++) run_cycle(1'b0, 4'b0110, rand_data(), 1'b1);

    // Operand change right after the handshake
    for (int i = 0; i < 8; i++) run_cycle(1'b0, 4'b0000, dat, 1'b1);
    dat = rand_data();
    run_cycle(1'b0, 4'b0010, dat, 1'b1);
    dat[31:16] = ~dat[31:16];
    for (int i = 0; i < 8; i++) run_cycle(1'b0, 4'b0010, dat, 1'b1);

    // Randomized traffic with backpressure and occasional reset
    for (int i = 0; i < 1500; i++) begin
      run_cycle(($urandom_range(0, 99) == 0), N'($urandom),
                rand_data(), ($urandom_range(0, 3) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
